// File: rtl/des_pkg.sv
// Shared DES constants: half-block widths and the Feistel expansion (E) table.
// The table lists 1-based source bits of R for output bits 1..48, DES numbering (bit 1 = MSB).
package des_pkg;

    localparam int DES_R_W    = 32;
    localparam int DES_E_W    = 48;
    localparam int DES_BLK_W  = 6;
    localparam int DES_BLOCKS = DES_E_W / DES_BLK_W;

    localparam int E_TABLE [DES_E_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    // Vector index of DES bit n (1-based, MSB first) inside a w-bit slice.
    function automatic int des_bit_idx(input int w, input int n);
        return w - n;
    endfunction

endpackage

// File: rtl/des_e_lane.sv
// One combinational 32->48 DES expansion lane; pure wiring driven by the E table.
module des_e_lane
    import des_pkg::*;
(
    input  logic [DES_R_W-1:0] r,
    output logic [DES_E_W-1:0] e
);

    for (genvar j = 0; j < DES_E_W; j++) begin : g_bit
        assign e[des_bit_idx(DES_E_W, j + 1)] = r[des_bit_idx(DES_R_W, E_TABLE[j])];
    end

endmodule

// File: rtl/des_expand_xor_pipe.sv
// Two-stage, multi-lane DES expansion with optional subkey XOR and a completed-transfer counter.
// Handshake: a transfer moves when valid && ready on that side; ready never depends on valid.
module des_expand_xor_pipe
    import des_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                     wClk,
    input  logic                     wRstN,
    input  logic                     wFlush,
    input  logic                     wInValid,
    output logic                     rInReady,
    input  logic                     wXorEn,
    input  logic [DES_R_W*LANES-1:0] wData,
    input  logic [DES_E_W*LANES-1:0] wKey,
    output logic                     rOutValid,
    input  logic                     wOutReady,
    output logic [DES_E_W*LANES-1:0] rData,
    output logic [CNT_W-1:0]         rCount
);

    localparam int E_ALL_W = DES_E_W * LANES;

    logic [E_ALL_W-1:0] exp_comb;

    logic               s1_valid;
    logic [E_ALL_W-1:0] s1_exp;
    logic [E_ALL_W-1:0] s1_key;
    logic               s1_xor_en;
    logic               s2_valid;

    logic               s1_load;
    logic               s2_load;
    logic               out_fire;
    logic [E_ALL_W-1:0] s2_next;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        des_e_lane u_lane (
            .r (wData[DES_R_W*i +: DES_R_W]),
            .e (exp_comb[DES_E_W*i +: DES_E_W])
        );
    end

    // S2 may take a new item in the same cycle it hands the old one downstream.
    assign s2_load   = s1_valid && (!s2_valid || wOutReady);
    assign rInReady  = !s1_valid || s2_load;
    assign s1_load   = wInValid && rInReady;
    assign out_fire  = s2_valid && wOutReady;
    assign s2_next   = s1_exp ^ (s1_key & {E_ALL_W{s1_xor_en}});
    assign rOutValid = s2_valid;

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            s1_valid <= 1'b0;
        end else if (wFlush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Data registers move only on their load enable, so a flush leaves them as they were.
    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            s1_exp    <= '0;
            s1_key    <= '0;
            s1_xor_en <= 1'b0;
        end else if (s1_load && !wFlush) begin
            s1_exp    <= exp_comb;
            s1_key    <= wKey;
            s1_xor_en <= wXorEn;
        end
    end

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            s2_valid <= 1'b0;
        end else if (wFlush) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            rData <= '0;
        end else if (s2_load && !wFlush) begin
            rData <= s2_next;
        end
    end

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            rCount <= '0;
        end else if (out_fire && !wFlush) begin
            rCount <= rCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_des_expand_xor_pipe.sv
// Directed bench for des_expand_xor_pipe: hand-computed E(R) vectors, streaming, stall, flush, reset, counter wrap.
module tb_des_expand_xor_pipe;

    localparam int LANES = 2;
    localparam int W     = 48 * LANES;

    logic            wClk = 1'b0;
    logic            wRstN;
    logic            wFlush;
    logic            wInValid;
    logic            wXorEn;
    logic [63:0]     wData;
    logic [W-1:0]    wKey;
    logic            wOutReady;
    logic            rInReady;
    logic            rOutValid;
    logic [W-1:0]    rData;
    logic [15:0]     rCount;
    logic            rInReady4;
    logic            rOutValid4;
    logic [W-1:0]    rData4;
    logic [3:0]      rCount4;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    // Hand-derived E(R) values for a set of right halves.
    logic [31:0] tbl_r [8] = '{32'hF0AAF0AA, 32'h00000001, 32'h80000000, 32'hFFFFFFFF,
                               32'h00000000, 32'h0000000F, 32'hF0000000, 32'hAAAAAAAA};
    logic [47:0] tbl_e [8] = '{48'h7A15557A1555, 48'h800000000002, 48'h400000000001, 48'hFFFFFFFFFFFF,
                               48'h000000000000, 48'h80000000005E, 48'h7A0000000001, 48'h555555555555};

    always #5 wClk = ~wClk;

    des_expand_xor_pipe #(.LANES(LANES), .CNT_W(16)) dut (
        .wClk(wClk), .wRstN(wRstN), .wFlush(wFlush), .wInValid(wInValid), .rInReady(rInReady),
        .wXorEn(wXorEn), .wData(wData), .wKey(wKey), .rOutValid(rOutValid), .wOutReady(wOutReady),
        .rData(rData), .rCount(rCount)
    );

    des_expand_xor_pipe #(.LANES(LANES), .CNT_W(4)) dut4 (
        .wClk(wClk), .wRstN(wRstN), .wFlush(wFlush), .wInValid(wInValid), .rInReady(rInReady4),
        .wXorEn(wXorEn), .wData(wData), .wKey(wKey), .rOutValid(rOutValid4), .wOutReady(wOutReady),
        .rData(rData4), .rCount(rCount4)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_exp(input int i0, input int i1, input logic [W-1:0] k, input logic x);
        logic [W-1:0] m;
        m = x ? k : '0;
        return {tbl_e[i1], tbl_e[i0]} ^ m;
    endfunction

    task automatic send(input logic [63:0] d, input logic [W-1:0] k, input logic x,
                        input logic [W-1:0] e, input bit push);
        bit acc;
        acc = 1'b0;
        wData = d; wKey = k; wXorEn = x; wInValid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge wClk);
            acc = rInReady;
            @(posedge wClk);
            #1;
        end
        check_eq("send_accept", W'(acc), W'(1));
        if (acc && push) exp_q.push_back(e);
        wInValid = 1'b0;
    endtask

    task automatic send_idx(input int i0, input int i1, input logic [W-1:0] k, input logic x, input bit push);
        send({tbl_r[i1], tbl_r[i0]}, k, x, mk_exp(i0, i1, k, x), push);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge wClk);
        check_eq("drain", W'(exp_q.size()), W'(0));
        @(posedge wClk);
        #1;
    endtask

    // Scoreboard: every counted output transfer must match the oldest expected item.
    always @(negedge wClk) begin
        if (wRstN && !wFlush && rOutValid && wOutReady) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", rData, '0);
            end else begin
                check_eq("out_data", rData, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] k_s;
    logic [W-1:0] held;

    initial begin
        wRstN = 1'b0; wFlush = 1'b0; wInValid = 1'b0; wXorEn = 1'b0;
        wData = '0; wKey = '0; wOutReady = 1'b1;
        k_s = {48'hA5A50F0F3C3C, 48'h123456789ABC};
        repeat (2) @(posedge wClk);
        #1;
        check_eq("rst_out_valid", W'(rOutValid), W'(0));
        check_eq("rst_data", rData, '0);
        check_eq("rst_count", W'(rCount), W'(0));
        check_eq("rst_in_ready", W'(rInReady), W'(1));
        @(negedge wClk) wRstN = 1'b1;
        @(posedge wClk);
        #1;

        // Round-1 vector with subkey XOR, checking the two-cycle latency explicitly.
        wData = {32'hFFFFFFFF, 32'hF0AAF0AA};
        wKey = {48'h0, 48'h1B02EFFC7072};
        wXorEn = 1'b1; wInValid = 1'b1;
        exp_q.push_back({48'hFFFFFFFFFFFF, 48'h6117BA866527});
        @(negedge wClk);
        check_eq("lat_in_ready", W'(rInReady), W'(1));
        @(posedge wClk);
        #1 wInValid = 1'b0;
        @(negedge wClk);
        check_eq("lat_cycle1", W'(rOutValid), W'(0));
        @(negedge wClk);
        check_eq("lat_cycle2", W'(rOutValid), W'(1));
        @(posedge wClk);
        #1;

        send({32'hFFFFFFFF, 32'hF0AAF0AA}, {48'h0, 48'h1B02EFFC7072}, 1'b0,
             {48'hFFFFFFFFFFFF, 48'h7A15557A1555}, 1'b1);
        send({32'h55555555, 32'h00000001}, '0, 1'b0, {48'hAAAAAAAAAAAA, 48'h800000000002}, 1'b1);
        send({32'hAAAAAAAA, 32'h80000000}, '0, 1'b0, {48'h555555555555, 48'h400000000001}, 1'b1);
        send({32'h0000000F, 32'hFFFFFFFF}, '0, 1'b0, {48'h80000000005E, 48'hFFFFFFFFFFFF}, 1'b1);
        drain();
        check_eq("count_directed", W'(rCount), W'(5));

        fork
            begin
                for (int i = 0; i < 8; i++) send_idx(i, 7 - i, k_s, i[0], 1'b1);
            end
            begin
                int n;
                n = 0;
                @(negedge wClk);
                while (!rOutValid && n < 20) begin
                    @(negedge wClk);
                    n++;
                end
                for (int i = 0; i < 8; i++) begin
                    check_eq("stream_no_bubble", W'(rOutValid), W'(1));
                    @(negedge wClk);
                end
            end
        join
        drain();
        check_eq("count_stream", W'(rCount), W'(13));

        fork
            begin
                for (int i = 0; i < 10; i++) send_idx(i % 8, (i + 2) % 8, k_s, 1'b1, 1'b1);
            end
            begin
                int n;
                n = 0;
                @(negedge wClk);
                while (!rOutValid && n < 20) begin
                    @(negedge wClk);
                    n++;
                end
                @(negedge wClk);
                @(posedge wClk);
                #1 wOutReady = 1'b0;
                @(negedge wClk);
                held = rData;
                check_eq("stall_valid", W'(rOutValid), W'(1));
                for (int c = 2; c <= 5; c++) begin
                    @(negedge wClk);
                    check_eq("stall_hold", rData, held);
                    check_eq("stall_in_ready", W'(rInReady), W'(0));
                end
                @(posedge wClk);
                #1 wOutReady = 1'b1;
            end
        join
        drain();
        check_eq("count_backpressure", W'(rCount), W'(23));

        // Fill S1 and S2 under stall, then flush with a new input and a would-be fire.
        wOutReady = 1'b0;
        send_idx(4, 5, '0, 1'b0, 1'b0);
        send_idx(5, 4, '0, 1'b0, 1'b0);
        wData = {tbl_r[6], tbl_r[6]}; wKey = '0; wXorEn = 1'b0;
        wInValid = 1'b1; wFlush = 1'b1; wOutReady = 1'b1;
        @(posedge wClk);
        #1 wFlush = 1'b0; wInValid = 1'b0;
        @(negedge wClk);
        check_eq("flush_valid", W'(rOutValid), W'(0));
        check_eq("flush_count", W'(rCount), W'(23));
        check_eq("flush_data_kept", rData, {tbl_e[5], tbl_e[4]});
        repeat (3) @(negedge wClk);
        check_eq("flush_quiet", W'(rOutValid), W'(0));
        @(posedge wClk);
        #1;

        fork
            begin
                for (int i = 0; i < 6; i++) send_idx(i, i, k_s, 1'b0, 1'b1);
            end
            begin
                repeat (3) @(posedge wClk);
                #3 wRstN = 1'b0;
                #1;
                check_eq("rst_async_valid", W'(rOutValid), W'(0));
                check_eq("rst_async_data", rData, '0);
                check_eq("rst_async_count", W'(rCount), W'(0));
                check_eq("rst_async_ready", W'(rInReady), W'(1));
                check_eq("rst_async_count4", W'(rCount4), W'(0));
            end
        join
        exp_q.delete();
        wInValid = 1'b0;
        @(negedge wClk) wRstN = 1'b1;
        @(posedge wClk);
        #1;

        for (int i = 0; i < 17; i++) send_idx(i % 8, (i + 5) % 8, k_s, i[1], 1'b1);
        drain();
        check_eq("wrap_count4", W'(rCount4), W'(1));
        check_eq("count_after_reset", W'(rCount), W'(17));
        check_eq("queue_empty", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/des_expand_xor_pipe.md
Name: des_expand_xor_pipe

Overview:
Parametrised, pipelined successor of the DES Feistel expansion stage. Each lane takes a 32-bit right half and a 48-bit round subkey, and produces E(R), optionally XORed with the subkey. Lanes run in parallel, so one instance serves several concurrent DES/3DES datapaths. Sits between the round register and the S-box stage, with a valid/ready handshake on both sides.

Parameters:
LANES, 2, number of independent 32->48 lanes processed per transfer
CNT_W, 16, width of the completed-transfer counter

Ports:
wClk  input  1  clock, all state rising-edge
wRstN  input  1  asynchronous active-low reset
wFlush  input  1  synchronous pipeline clear, same-cycle priority over everything except reset
wInValid  input  1  input transfer valid
rInReady  output  1  input transfer accepted when wInValid && rInReady
wXorEn  input  1  1: output E(R) xor K; 0: output E(R) only; sampled with data
wData  input  32*LANES  right halves; lane i = bits [32*i +: 32]
wKey  input  48*LANES  subkeys; lane i = bits [48*i +: 48]
rOutValid  output  1  output transfer valid
wOutReady  input  1  downstream ready
rData  output  48*LANES  results; lane i = bits [48*i +: 48]
rCount  output  CNT_W  number of completed output transfers, modulo 2^CNT_W

Behaviour:
- Reset: wClk single clock domain; wRstN asynchronous assert, active-low. On reset: stage valids=0, rOutValid=0, rData=0, rCount=0, rInReady=1.
- Bit numbering within a lane follows DES: bit 1 = MSB of the slice, bit 32/48 = LSB.
- Expansion: output block k (k=0..7, 6 bits each, MSB first) = input bits 4k, 4k+1, 4k+2, 4k+3, 4k+4, 4k+5, with index 0 mapping to 32 and index 33 mapping to 1.
- Stage 1 (S1): on accept, registers E(wData) per lane, wKey, and wXorEn.
- Stage 2 (S2, output register): registers S1 expansion XOR (S1 key masked by S1 xor-enable). rData and rOutValid are driven directly from S2 registers.
- Latency: 2 cycles from accept to rOutValid with no stall. Throughput: 1 transfer/cycle.
- Advance rules:
  - S2 loads when S1 valid && (!S2 valid || wOutReady).
  - S1 loads when wInValid && rInReady.
  - rInReady = !S1 valid || S2 load condition; combinational, no dependence on wInValid.
- Stall: while rOutValid && !wOutReady, rData holds bit-stable. S1 holds. rInReady=0 once S1 is full.
- Output fire (rOutValid && wOutReady): rCount increments by 1 and wraps from 2^CNT_W-1 to 0. Simultaneous fire and S2 reload is legal; no bubble.
- rData after a fire with no reload: retains its last value; only rOutValid drops.
- wFlush: next edge clears both valids. A same-cycle input is dropped and a same-cycle fire is not counted. rCount and data registers are untouched.
- Lanes are fully independent; the shared handshake means all lanes move together.
- No X propagation: data registers load only on stage-load enables.

Decomposition:
- Package des_pkg: DES_R_W=32, DES_E_W=48, and the E-table as a 48-entry constant array of 1-based source indices, shared with the future P-box and S-box blocks.
- Sub-module des_e_lane: purely combinational 32->48 expansion, instantiated LANES times with generate.
- Pipeline control, XOR, and counter stay in the top.

Test Plan:
1. Known DES round-1 vector, lane 0: wData=0xF0AAF0AA, wKey=0x1B02EFFC7072, wXorEn=1 -> 2 cycles later rData lane0=0x6117BA866527. Same input with wXorEn=0 -> 0x7A15557A1555.
2. Wrap bits, lane 0: wData=0x00000001 -> 0x800000000002; wData=0x80000000 -> 0x400000000001; wData=0xFFFFFFFF -> 0xFFFFFFFFFFFF. All with wXorEn=0; lane 1 is driven with different data and must be unaffected.
3. Back-to-back stream of 8 transfers with wOutReady=1 -> 8 consecutive rOutValid cycles with no bubbles, results in order, rCount=8.
4. Backpressure: hold wOutReady=0 for 5 cycles mid-stream -> rData stable, rInReady=0 from the second stalled cycle. On release, no loss or duplication; rCount matches the number of fires.
5. wFlush asserted while S1 and S2 are both valid and wInValid=1 -> next cycle rOutValid=0, no output for the flushed items, rCount unchanged.
6. Reset mid-stream, plus counter wrap with CNT_W=4:
   - Assert wRstN=0 between edges -> outputs zero immediately, without waiting for an edge.
   - CNT_W=4 build: 17 fires -> rCount=1.
